uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; the counterpart of the team's uart_tx on the same serial line.
//  - Deserialises frames: start(0), 8 data bits LSB-first, optional parity, stop(1).
//  - Reports the byte and per-frame parity/framing status with a one-cycle valid pulse.
//  - Sits between the pad-side rx line and the byte-level consumer.
//  - Default CLKS_PER_BIT=1 matches uart_tx, which sends one bit per clk.
// PARAMETERS
//  CLKS_PER_BIT  1  clk cycles per serial bit (>=1); HALF=(CLKS_PER_BIT-1)/2
// PORTS
//  clk          in   1  single clock, all logic on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  rx           in   1  serial line, idle high
//  parity_en    in   1  1: frame carries a parity bit
//  even_parity  in   1  1: even parity (bit=^data); 0: odd parity (bit=~^data)
//  data_out     out  8  last received byte, held until next frame
//  rx_valid     out  1  one-cycle pulse: data_out/parity_err/frame_err valid
//  rx_busy      out  1  high from start detection until FSM back in IDLE
//  parity_err   out  1  parity mismatch on last frame (0 when parity_en=0)
//  frame_err    out  1  stop bit sampled 0 on last frame
// BEHAVIOUR
//  Reset: data_out=0, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0;
//    FSM=IDLE, counters=0, synchroniser flops=1. Async reset mid-frame discards the frame.
//  rx_s: rx, or the synchronised rx when UART_RX_SYNC_EN is defined.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//  IDLE:
//    - rx_s==0 -> latch parity_en/even_parity, rx_busy=1, bit-timer=HALF.
//    - If HALF==0, this sample is the start check: go to DATA, timer=CLKS_PER_BIT-1.
//    - Otherwise go to START.
//  START: timer counts down to 0, then re-sample rx_s.
//    - rx_s==0: go to DATA, timer=CLKS_PER_BIT-1.
//    - rx_s==1: false start; go to IDLE, rx_busy=0, no rx_valid.
//  DATA: sample rx_s when timer reaches 0.
//    - Shift into bit[idx], idx 0..7; reload timer.
//    - After idx 7 go to PARITY if parity_en latched, else STOP.
//  PARITY: sample once; parity_err_next = sample != expected bit.
//  STOP: sample once.
//    - Update data_out, parity_err, frame_err(=~sample); pulse rx_valid next cycle.
//    - sample==1 -> IDLE (rx_busy=0); a new frame may start next cycle, so back-to-back frames work.
//    - sample==0 -> WAIT_IDLE (rx_busy stays 1).
//  WAIT_IDLE: hold until rx_s==1, then IDLE. A line held low (break) never re-triggers.
//  Latency: rx_valid asserts on the clk edge after the edge sampling the stop bit.
//    Plus 2 cycles with UART_RX_SYNC_EN.
//  Config changes mid-frame are ignored; the values latched at start detection apply.
//  Bit index: 3 bits; bit-timer: $clog2(CLKS_PER_BIT+1) bits. No wrap beyond reload values.
// CONFIGURATION
//  UART_RX_SYNC_EN defined: rx passes through a 2-flop synchroniser (reset to 1).
//    Adds exactly 2 cycles of latency to every event.
//  Undefined: rx_s=rx directly. Use only when rx is already in the clk domain.
// STRUCTURE
//  Package uart_pkg:
//    - typedef enum logic[2:0] rx_state_e {IDLE,START,DATA,PARITY,STOP,WAIT_IDLE}
//    - localparam DATA_BITS=8
//    - function calc_parity(data,even)
//  Sub-module uart_rx_sync: 2-flop synchroniser, instantiated only under UART_RX_SYNC_EN.
// TESTING (CLKS_PER_BIT=1, macro undefined unless stated)
//  1. parity_en=0; rx=0,1,0,1,0,0,1,0,1 (0xA5) then 1
//     -> rx_valid 1 cycle, data_out=0xA5, both errs 0.
//  2. parity_en=1, even_parity=1; 0xA5 with parity bit 0 -> parity_err=0.
//     Repeat with parity bit 1 -> parity_err=1, data_out=0xA5.
//  3. Odd parity, 0x01 with parity bit 0 -> parity_err=0. Two frames back-to-back, no idle
//     -> two rx_valid pulses, data 0x01 then 0x80.
//  4. Stop bit 0, rx held low 5 cycles -> frame_err=1, rx_busy stays 1.
//     No second rx_valid until rx high; then returns to IDLE.
//  5. CLKS_PER_BIT=4; rx low 1 cycle then high -> rx_valid never pulses, rx_busy drops within 2 cycles.
//  6. rst_n low during data bit 3 -> all outputs 0 immediately.
//     Next full 0x3C frame received correctly. Repeat with UART_RX_SYNC_EN: rx_valid 2 cycles later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int DATA_BITS = 8;

    // Parity bit a transmitter would append: even -> ^data, odd -> ~^data.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic even);
        return even ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the pad-side rx line; both flops reset to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous line through two flops before any logic looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Build option: define UART_RX_SYNC_EN to pass rx through a 2-flop synchroniser
// (adds 2 cycles to every event); otherwise rx must already be in the clk domain.
//
//  state     | meaning
//  IDLE      | waiting for rx_s low (start edge)
//  START     | timing to mid start bit, re-check for false start
//  DATA      | sampling the 8 data bits
//  PARITY    | sampling the parity bit
//  STOP      | sampling the stop bit, publishing the frame
//  WAIT_IDLE | stop bit was 0; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       even_parity,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic w_rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(rx),
        .o_sync (w_rx_s)
    );
`else
    assign w_rx_s = rx;
`endif

    rx_state_e r_state, w_state_next;
    logic [TW-1:0]          r_timer, w_timer_next;
    logic [2:0]             r_idx, w_idx_next;
    logic [DATA_BITS-1:0]   r_shift, w_shift_next;
    logic                   r_par_en, w_par_en_next;
    logic                   r_even, w_even_next;
    logic                   r_perr, w_perr_next;
    logic [DATA_BITS-1:0]   r_data_out, w_data_out_next;
    logic                   r_parity_err, w_parity_err_next;
    logic                   r_frame_err, w_frame_err_next;
    logic                   r_valid_pend, w_valid_pend_next;
    logic                   r_rx_valid;
    logic                   r_rx_busy;
    logic                   w_tick;

    assign w_tick = (r_timer == '0);

    // State and datapath registers; rx_valid trails the stop-bit sample by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_even       <= 1'b0;
            r_perr       <= 1'b0;
            r_data_out   <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_valid_pend <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_idx        <= w_idx_next;
            r_shift      <= w_shift_next;
            r_par_en     <= w_par_en_next;
            r_even       <= w_even_next;
            r_perr       <= w_perr_next;
            r_data_out   <= w_data_out_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
            r_valid_pend <= w_valid_pend_next;
            r_rx_valid   <= r_valid_pend;
            r_rx_busy    <= (w_state_next != IDLE);
        end
    end

    // Next-state and datapath decode; every bit sample happens when the timer hits 0.
    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_idx_next        = r_idx;
        w_shift_next      = r_shift;
        w_par_en_next     = r_par_en;
        w_even_next       = r_even;
        w_perr_next       = r_perr;
        w_data_out_next   = r_data_out;
        w_parity_err_next = r_parity_err;
        w_frame_err_next  = r_frame_err;
        w_valid_pend_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_par_en_next = parity_en;
                    w_even_next   = even_parity;
                    w_perr_next   = 1'b0;
                    w_idx_next    = '0;
                    if (HALF == 0) begin
                        // No half-bit wait: this sample already confirms the start bit.
                        w_state_next = DATA;
                        w_timer_next = T_FULL;
                    end else begin
                        w_state_next = START;
                        w_timer_next = T_HALF;
                    end
                end
            end
            START: begin
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_state_next = DATA;
                        w_timer_next = T_FULL;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next[r_idx] = w_rx_s;
                    w_timer_next        = T_FULL;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_perr_next  = (w_rx_s != calc_parity(r_shift, r_even));
                    w_timer_next = T_FULL;
                    w_state_next = STOP;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_data_out_next   = r_shift;
                    w_parity_err_next = r_par_en & r_perr;
                    w_frame_err_next  = ~w_rx_s;
                    w_valid_pend_next = 1'b1;
                    w_state_next      = w_rx_s ? IDLE : WAIT_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not look like a fresh start bit.
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign data_out   = r_data_out;
    assign rx_valid   = r_rx_valid;
    assign rx_busy    = r_rx_busy;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance at 1 clk/bit, one at 4 clks/bit.
// Expected frame results are queued when a frame is driven and checked on rx_valid.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       parity_en;
    logic       even_parity;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    logic       rx4;
    logic [7:0] data_out4;
    logic       rx_valid4;
    logic       rx_busy4;
    logic       parity_err4;
    logic       frame_err4;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_valid4 = 0;
    logic prev_valid = 1'b0;
    exp_t q[$];
    exp_t q4[$];
    exp_t m_e;
    exp_t m_e4;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_en  (parity_en),
        .even_parity(even_parity),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx4),
        .parity_en  (1'b0),
        .even_parity(1'b0),
        .data_out   (data_out4),
        .rx_valid   (rx_valid4),
        .rx_busy    (rx_busy4),
        .parity_err (parity_err4),
        .frame_err  (frame_err4)
    );

    // Scoreboard for the 1 clk/bit instance.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: data_out=%h perr=%b ferr=%b, no frame pending",
                         data_out, parity_err, frame_err);
            end else begin
                m_e = q.pop_front();
                if ({data_out, parity_err, frame_err} !== {m_e.d, m_e.pe, m_e.fe}) begin
                    n_err++;
                    $display("FAIL frame_result: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                             data_out, parity_err, frame_err, m_e.d, m_e.pe, m_e.fe);
                end
            end
            n_vec++;
            if (prev_valid) begin
                n_err++;
                $display("FAIL valid_width: rx_valid high 2 cycles in a row, expected 1-cycle pulse");
            end
        end
        prev_valid = rx_valid;
    end

    // Scoreboard for the 4 clk/bit instance.
    always @(negedge clk) begin
        if (rx_valid4) begin
            n_valid4++;
            n_vec++;
            if (q4.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid4: data_out=%h, no frame pending", data_out4);
            end else begin
                m_e4 = q4.pop_front();
                if ({data_out4, parity_err4, frame_err4} !== {m_e4.d, m_e4.pe, m_e4.fe}) begin
                    n_err++;
                    $display("FAIL frame_result4: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                             data_out4, parity_err4, frame_err4, m_e4.d, m_e4.pe, m_e4.fe);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one 1 clk/bit frame; returns right after the stop bit is driven.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic flip_cfg);
        logic exp_bit;
        logic pe;
        exp_bit = even_parity ? (^d) : ~(^d);
        pe      = parity_en ? (pbit != exp_bit) : 1'b0;
        q.push_back('{d, pe, ~stop});
        @(negedge clk) rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = d[i];
            if (flip_cfg && i == 0) even_parity = ~even_parity;
        end
        if (parity_en ^ 1'b0) begin
            @(negedge clk) rx = pbit;
        end
        @(negedge clk) rx = stop;
        if (flip_cfg) even_parity = ~even_parity;
    endtask

    task automatic send_frame4(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        q4.push_back('{d, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx4 = bits[i];
            repeat (3) @(negedge clk);
        end
    endtask

    // Cycles (negedges) from driving the stop bit until rx_valid is seen.
    task automatic measure_latency(output int got);
        got = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rx_valid && got < 0) got = k;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b1; rx4 = 1'b1; parity_en = 1'b0; even_parity = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, expected 00", data_out); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
        n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", rx_busy); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b, expected 0", parity_err); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        n_vec++; if (rx_busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy4: got %b, expected 0", rx_busy4); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        int got;
        parity_en = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        measure_latency(got);
        n_vec++;
        if (got !== 2 + LAT) begin
            n_err++; $display("FAIL basic_latency: got %0d cycles, expected %0d", got, 2 + LAT);
        end
        n_vec++;
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle: got %b, expected 0", rx_busy); end
    endtask

    task automatic test_parity;
        parity_en = 1'b1; even_parity = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = n_valid;
        parity_en = 1'b1; even_parity = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        n_vec++;
        if (n_valid - n0 !== 2) begin
            n_err++; $display("FAIL b2b_count: got %0d pulses, expected 2", n_valid - n0);
        end
    endtask

    task automatic test_frame_err;
        int n0;
        int low_k;
        n0 = n_valid;
        parity_en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy: cycle %0d got %b, expected 1", k, rx_busy); end
        end
        n_vec++;
        if (n_valid - n0 !== 1) begin n_err++; $display("FAIL break_valid: got %0d pulses, expected 1", n_valid - n0); end
        rx = 1'b1;
        low_k = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!rx_busy && low_k < 0) low_k = k;
        end
        n_vec++;
        if (low_k < 0 || low_k > 2 + LAT) begin
            n_err++; $display("FAIL break_release: busy low after %0d cycles, expected <= %0d", low_k, 2 + LAT);
        end
        repeat (12) @(negedge clk);
        n_vec++;
        if (n_valid - n0 !== 1) begin n_err++; $display("FAIL break_retrigger: got %0d pulses, expected 1", n_valid - n0); end
    endtask

    task automatic test_false_start;
        logic saw;
        logic vseen;
        int   low_k;
        saw = 1'b0; vseen = 1'b0; low_k = -1;
        @(negedge clk) rx4 = 1'b0;
        @(negedge clk) rx4 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (rx_busy4) saw = 1'b1;
            else if (saw && low_k < 0) low_k = k;
            if (rx_valid4) vseen = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (saw !== 1'b1) begin n_err++; $display("FAIL false_start_busy: busy never rose, expected 1"); end
        n_vec++;
        if (low_k !== 2 + LAT) begin n_err++; $display("FAIL false_start_drop: busy low at %0d, expected %0d", low_k, 2 + LAT); end
        n_vec++;
        if (vseen !== 1'b0) begin n_err++; $display("FAIL false_start_valid: got valid pulse, expected none"); end
    endtask

    task automatic test_cpb4_frame;
        int n0;
        n0 = n_valid4;
        send_frame4(8'hC3);
        repeat (8) @(negedge clk);
        n_vec++;
        if (n_valid4 - n0 !== 1) begin n_err++; $display("FAIL cpb4_count: got %0d pulses, expected 1", n_valid4 - n0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int got;
        d = 8'h3C;
        parity_en = 1'b0;
        @(negedge clk) rx = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk) rx = d[i];
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({data_out, rx_valid, rx_busy, parity_err, frame_err} !== 12'h000) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got data=%h v=%b busy=%b perr=%b ferr=%b, expected all 0",
                     data_out, rx_valid, rx_busy, parity_err, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(d, 1'b0, 1'b1, 1'b0);
        measure_latency(got);
        n_vec++;
        if (got !== 2 + LAT) begin n_err++; $display("FAIL mid_reset_latency: got %0d, expected %0d", got, 2 + LAT); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_back_to_back;
        test_frame_err;
        test_false_start;
        test_cpb4_frame;
        test_reset_mid;
        repeat (5) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL pending_frames: %0d left, expected 0", q.size()); end
        n_vec++;
        if (q4.size() != 0) begin n_err++; $display("FAIL pending_frames4: %0d left, expected 0", q4.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
